// File: rtl/lfsr_disp_pkg.sv
// LFSR hex display shared types and constants.
// Active-low 7-segment codes, bit0..6 = a..g, bit7 = dp.
package lfsr_disp_pkg;

  typedef logic [7:0] seg7_t;

  localparam seg7_t SEG_BLANK = 8'hFF;

  localparam seg7_t SEG7_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern.
// Decimal point is always off.
module hex_to_seg7
  import lfsr_disp_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  assign seg = SEG7_LUT[hex];

endmodule

// File: rtl/lfsr_hex_display.sv
// Fibonacci LFSR stepped by button edge or prescaled tick.
// Each state nibble drives one registered 7-segment digit.
module lfsr_hex_display
  import lfsr_disp_pkg::*;
#(
  parameter int          W     = 8,
  parameter logic [W-1:0] TAPS = W'('h1D),
  parameter logic [W-1:0] SEED = W'('h01),
  parameter int unsigned DIV   = 50_000_000,
  parameter int          CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [W-1:0]       din,
  input  logic               step_btn,
  input  logic               run,
  output logic [W-1:0]       dout,
  output logic [CNT_W-1:0]   step_cnt,
  output logic [8*(W/4)-1:0] segment_dis
);

  localparam int NDIG = W / 4;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;

  if (W % 4 != 0) begin : g_bad_w
    $error("lfsr_hex_display: W must be a multiple of 4");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_hex_display: SEED must be nonzero");
  end
  if (DIV < 1) begin : g_bad_div
    $error("lfsr_hex_display: DIV must be >= 1");
  end

  logic          s1, s2, prev;
  logic          step_edge;
  logic [PW-1:0] pre;
  logic          tick;
  logic          fb;
  logic [8*NDIG-1:0] seg_w;

  assign step_edge = s2 & ~prev;
  assign tick      = run && (pre == PW'(DIV - 1));
  assign fb        = ^(dout & TAPS);

  // Button synchroniser plus previous-value flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= step_btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Free-run prescaler, parked at zero when idle or loading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (load || !run) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // LFSR state and shift counter; load beats any step source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= SEED;
      step_cnt <= '0;
    end else if (load) begin
      dout     <= (din == '0) ? SEED : din;
      step_cnt <= '0;
    end else if (step_edge || tick) begin
      dout     <= {fb, dout[W-1:1]};
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    hex_to_seg7 u_seg (
      .hex (dout[4*k +: 4]),
      .seg (seg_w[8*k +: 8])
    );
  end

  // Registered segment outputs, blank while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment_dis <= {NDIG{SEG_BLANK}};
    end else begin
      segment_dis <= seg_w;
    end
  end

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Scoreboard bench for lfsr_hex_display (W=8, DIV=4, CNT_W=8).
// Reference model predicts per-cycle outputs from input history.
module tb_lfsr_hex_display;

  localparam int DIV = 4;

  typedef struct packed {
    logic [7:0]  d;
    logic [7:0]  c;
    logic [15:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        step_btn = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  dout;
  logic [7:0]  step_cnt;
  logic [15:0] segment_dis;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];

  logic [7:0] SEGT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  lfsr_hex_display #(
    .W(8), .TAPS(8'h1D), .SEED(8'h01), .DIV(DIV), .CNT_W(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .din         (din),
    .step_btn    (step_btn),
    .run         (run),
    .dout        (dout),
    .step_cnt    (step_cnt),
    .segment_dis (segment_dis)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seg_of(logic [7:0] v);
    return {SEGT[v[7:4]], SEGT[v[3:0]]};
  endfunction

  function automatic logic [7:0] next_state(logic [7:0] v);
    logic fb;
    fb = ($countones(v & 8'h1D) % 2) == 1;
    return {fb, v[7:1]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one expectation per rising edge
  initial begin
    logic [7:0]  md;
    logic [7:0]  mc;
    logic [15:0] ms;
    int          runlen;
    bit          bq[$];
    bit          e, t;
    md = 8'h01; mc = 0; ms = 16'hFFFF; runlen = 0;
    bq = '{0, 0, 0};
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        md = 8'h01; mc = 0; ms = 16'hFFFF; runlen = 0;
        bq = '{0, 0, 0};
      end else begin
        ms = seg_of(md);
        e = bq[1] && !bq[0];
        t = 0;
        if (load || !run) runlen = 0;
        else begin
          runlen++;
          t = (runlen % DIV) == 0;
        end
        if (load) begin
          md = (din == 0) ? 8'h01 : din;
          mc = 0;
        end else if (e || t) begin
          md = next_state(md);
          mc = mc + 8'd1;
        end
        bq.push_back(step_btn);
        void'(bq.pop_front());
      end
      q.push_back('{d: md, c: mc, s: ms});
    end
  end

  // Monitor: compare DUT outputs with queued expectation
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("sb_dout", 32'(dout), 32'(x.d));
        chk("sb_cnt", 32'(step_cnt), 32'(x.c));
        chk("sb_seg", 32'(segment_dis), 32'(x.s));
        chk("nonzero", 32'(dout == 8'h00), 32'd0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(segment_dis), 32'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_seg", 32'(segment_dis), 32'hC0F9);
    @(negedge clk);

    // single step from a held button
    step_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("step_early", 32'(dout), 32'h01);
    @(negedge clk);
    chk("step_dout", 32'(dout), 32'h80);
    chk("step_cnt", 32'(step_cnt), 32'd1);
    @(negedge clk);
    chk("step_seg", 32'(segment_dis), 32'h80C0);
    @(negedge clk);
    step_btn = 1'b0;
    repeat (4) @(negedge clk);
    chk("step_hold", 32'(dout), 32'h80);

    // free-run spacing, freeze, restart
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      chk("run_gap", 32'(dout), 32'(8'h80 >> i));
      @(negedge clk);
      chk("run_tick", 32'(dout), 32'(8'h40 >> i));
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
    chk("run_frozen", 32'(dout), 32'h10);
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("run_restart_gap", 32'(dout), 32'h10);
    @(negedge clk);
    chk("run_restart", 32'(dout), 32'h88);
    chk("run_cnt", 32'(step_cnt), 32'd5);
    run = 1'b0;
    repeat (4) @(negedge clk);

    // step edge coinciding with tick
    run = 1'b1;
    @(negedge clk);
    step_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("coinc_gap", 32'(dout), 32'h88);
    @(negedge clk);
    chk("coinc_dout", 32'(dout), 32'hC4);
    chk("coinc_cnt", 32'(step_cnt), 32'd6);
    run = 1'b0;
    step_btn = 1'b0;
    repeat (4) @(negedge clk);

    // load zero, then load beating a step edge
    load = 1'b1; din = 8'h00;
    @(negedge clk);
    chk("load0_dout", 32'(dout), 32'h01);
    chk("load0_cnt", 32'(step_cnt), 32'd0);
    load = 1'b0;
    repeat (3) @(negedge clk);
    step_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load = 1'b1; din = 8'hA5;
    @(negedge clk);
    chk("loadw_dout", 32'(dout), 32'hA5);
    chk("loadw_cnt", 32'(step_cnt), 32'd0);
    load = 1'b0;
    @(negedge clk);
    chk("loadw_seg", 32'(segment_dis), 32'h8892);
    step_btn = 1'b0;
    repeat (3) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      load = ($urandom_range(0, 19) == 0);
      din = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 15) == 0) run = ~run;
      @(negedge clk);
    end
    load = 1'b0; step_btn = 1'b0; run = 1'b0;
    repeat (4) @(negedge clk);

    // full period and counter wrap
    load = 1'b1; din = 8'h01;
    @(negedge clk);
    load = 1'b0;
    run = 1'b1;
    repeat (1020) @(negedge clk);
    chk("period_dout", 32'(dout), 32'h01);
    chk("period_cnt", 32'(step_cnt), 32'd255);
    repeat (4) @(negedge clk);
    chk("wrap_cnt", 32'(step_cnt), 32'd0);
    repeat (10) @(negedge clk);

    // asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'h01);
    chk("arst_cnt", 32'(step_cnt), 32'd0);
    chk("arst_seg", 32'(segment_dis), 32'hFFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arel_seg", 32'(segment_dis), 32'hC0F9);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
